// File: rtl/collision_ci_pkg.sv
// Shared types and sizing for the collision custom-instruction driver.
package collision_ci_pkg;

  localparam int unsigned WORD_SIZE        = 32;
  localparam int unsigned TOTAL_WORDS      = 16;
  localparam int unsigned LOADS_PER_TARGET = 8;
  localparam int unsigned TARGET_BITS      = 5;
  localparam int unsigned PAIR_BITS        = $clog2(LOADS_PER_TARGET);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_ISSUE = 3'd1,
    ST_LD_WAIT  = 3'd2,
    ST_TG_ISSUE = 3'd3,
    ST_TG_WAIT  = 3'd4,
    ST_EMIT     = 3'd5
  } state_e;

endpackage

// File: rtl/collision_msg_buf.sv
// Message word buffer: synchronous write port, two combinational read ports.
module collision_msg_buf #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr_a,
  input  logic [AW-1:0]        raddr_b,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b
);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/collision_ci_driver.sv
// Drives the collision custom instruction: 8 message loads then one target query per result.
// Optional per-instruction watchdog enabled by defining CI_TIMEOUT_EN.
module collision_ci_driver
  import collision_ci_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = collision_ci_pkg::WORD_SIZE,
  parameter int unsigned TOTAL_WORDS    = collision_ci_pkg::TOTAL_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [3:0]             wr_addr,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic                   go,
  input  logic [TARGET_BITS-1:0] first_tgt,
  input  logic [TARGET_BITS-1:0] last_tgt,
  output logic                   busy,
  output logic                   ci_clk_en,
  output logic                   ci_reset,
  output logic                   ci_start,
  output logic                   ci_n,
  output logic [WORD_SIZE-1:0]   ci_dataa,
  output logic [WORD_SIZE-1:0]   ci_datab,
  input  logic                   ci_done,
  input  logic [WORD_SIZE-1:0]   ci_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [TARGET_BITS-1:0] res_target,
  output logic [WORD_SIZE-1:0]   res_data,
  output logic                   err
);

  state_e                 state_q, state_d;
  logic [PAIR_BITS-1:0]   pair_q, pair_d;
  logic [TARGET_BITS-1:0] tgt_q, tgt_d, last_q, last_d;
  logic                   res_valid_q, res_valid_d;
  logic [TARGET_BITS-1:0] res_target_q, res_target_d;
  logic [WORD_SIZE-1:0]   res_data_q, res_data_d;
  logic                   err_q, err_d;
  logic                   abort_q, abort_d;
  logic                   timeout;
  logic                   in_ld, in_tg;
  logic [WORD_SIZE-1:0]   rd_a, rd_b;

  collision_msg_buf #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (TOTAL_WORDS),
    .AW        (4)
  ) u_buf (
    .clk     (clk),
    .we      (wr_en && !busy),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a ({pair_q, 1'b0}),
    .raddr_b ({pair_q, 1'b1}),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

`ifdef CI_TIMEOUT_EN
  localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_BITS-1:0] wd_q, wd_d;

  always_comb begin
    wd_d    = wd_q;
    timeout = 1'b0;
    if (ci_start) begin
      wd_d = '0;
    end else if ((state_q == ST_LD_WAIT || state_q == ST_TG_WAIT) && !ci_done) begin
      wd_d    = wd_q + WD_BITS'(1);
      timeout = (wd_d == WD_BITS'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pair_d       = pair_q;
    tgt_d        = tgt_q;
    last_d       = last_q;
    res_valid_d  = res_valid_q;
    res_target_d = res_target_q;
    res_data_d   = res_data_q;
    err_d        = err_q;
    abort_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          tgt_d   = first_tgt;
          last_d  = last_tgt;
          pair_d  = '0;
          err_d   = 1'b0;
          state_d = ST_LD_ISSUE;
        end
      end
      ST_LD_ISSUE: state_d = ST_LD_WAIT;
      ST_LD_WAIT: begin
        if (ci_done) begin
          pair_d  = pair_q + PAIR_BITS'(1);
          state_d = (pair_q == PAIR_BITS'(LOADS_PER_TARGET - 1)) ? ST_TG_ISSUE : ST_LD_ISSUE;
        end
      end
      ST_TG_ISSUE: state_d = ST_TG_WAIT;
      ST_TG_WAIT: begin
        if (ci_done) begin
          res_data_d   = ci_result;
          res_target_d = tgt_q;
          res_valid_d  = 1'b1;
          state_d      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (tgt_q == last_q) begin
            state_d = ST_IDLE;
          end else begin
            tgt_d   = tgt_q + TARGET_BITS'(1);
            pair_d  = '0;
            state_d = ST_LD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Watchdog expiry overrides whatever the wait state decided.
    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pair_q       <= '0;
      tgt_q        <= '0;
      last_q       <= '0;
      res_valid_q  <= 1'b0;
      res_target_q <= '0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_q       <= pair_d;
      tgt_q        <= tgt_d;
      last_q       <= last_d;
      res_valid_q  <= res_valid_d;
      res_target_q <= res_target_d;
      res_data_q   <= res_data_d;
      err_q        <= err_d;
      abort_q      <= abort_d;
    end
  end

  // Operands decode from state; the buffer is write-locked while busy so they hold through WAIT.
  assign in_ld      = (state_q == ST_LD_ISSUE) || (state_q == ST_LD_WAIT);
  assign in_tg      = (state_q == ST_TG_ISSUE) || (state_q == ST_TG_WAIT);
  assign busy       = (state_q != ST_IDLE);
  assign ci_clk_en  = 1'b1;
  assign ci_reset   = reset || abort_q;
  assign ci_start   = (state_q == ST_LD_ISSUE) || (state_q == ST_TG_ISSUE);
  assign ci_n       = in_tg;
  assign ci_dataa   = in_ld ? rd_a : (in_tg ? WORD_SIZE'(tgt_q) : '0);
  assign ci_datab   = in_ld ? rd_b : '0;
  assign res_valid  = res_valid_q;
  assign res_target = res_target_q;
  assign res_data   = res_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_collision_ci_driver.sv
// Randomized self-checking bench: instruction/result queues predicted from the message and target range.
module tb_collision_ci_driver;

  localparam logic [31:0] K = 32'h9E3779B1;

  logic        clk = 1'b0;
  logic        reset, wr_en, go, ci_done, res_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data, ci_result;
  logic [4:0]  first_tgt, last_tgt;
  logic        busy, ci_clk_en, ci_reset, ci_start, ci_n, res_valid, err;
  logic [31:0] ci_dataa, ci_datab, res_data;
  logic [4:0]  res_target;

  always #5 clk = ~clk;

  collision_ci_driver #(
    .WORD_SIZE      (32),
    .TOTAL_WORDS    (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk), .reset (reset), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .go (go), .first_tgt (first_tgt), .last_tgt (last_tgt), .busy (busy),
    .ci_clk_en (ci_clk_en), .ci_reset (ci_reset), .ci_start (ci_start), .ci_n (ci_n),
    .ci_dataa (ci_dataa), .ci_datab (ci_datab), .ci_done (ci_done), .ci_result (ci_result),
    .res_valid (res_valid), .res_ready (res_ready), .res_target (res_target),
    .res_data (res_data), .err (err)
  );

  typedef struct packed { logic n; logic [31:0] a; logic [31:0] b; } insn_t;
  typedef struct packed { logic [4:0] t; logic [31:0] d; } res_t;

  int unsigned n_pass = 0, n_total = 0;
  int unsigned starts_seen = 0, results_seen = 0;
  int unsigned lat_min = 3, lat_max = 3, ready_pct = 100;
  bit          resp_on = 1'b1, spurious = 1'b0;
  logic [31:0] msg [16];
  insn_t       exp_insn [$];
  res_t        exp_res [$];
  insn_t       obs_insn [$];
  logic [4:0]  obs_tgt [$];

  function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [31:0] model_result(input logic [4:0] t);
    logic [31:0] acc;
    acc = '0;
    for (int p = 0; p < 8; p++) acc = acc + msg[2*p] * 32'd3 + msg[2*p+1];
    return acc ^ ({27'd0, t} * K);
  endfunction

  function automatic void plan_run(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] t;
    t = f;
    for (int k = 0; k < 32; k++) begin
      for (int p = 0; p < 8; p++) exp_insn.push_back({1'b0, msg[2*p], msg[2*p+1]});
      exp_insn.push_back({1'b1, {27'd0, t}, 32'd0});
      exp_res.push_back({t, model_result(t)});
      if (t == l) break;
      t = t + 5'd1;
    end
  endfunction

  // Responder: checks each issued instruction, answers after a random latency.
  initial begin
    int unsigned cnt;
    logic [31:0] acc, pend;
    insn_t got, held, e;
    cnt = 0; acc = '0; pend = '0; held = '0;
    ci_done = 1'b0; ci_result = '0;
    forever begin
      @(posedge clk); #1;
      ci_done = 1'b0;
      if (reset) begin
        cnt = 0; acc = '0;
      end else if (ci_start) begin
        starts_seen++;
        got = {ci_n, ci_dataa, ci_datab};
        obs_insn.push_back(got);
        held = got;
        check("start_expected", {95'd0, exp_insn.size() != 0}, 96'd1);
        if (exp_insn.size() != 0) begin
          e = exp_insn.pop_front();
          check("insn", got, e);
        end
        if (ci_n) begin pend = acc ^ (ci_dataa * K); acc = '0; end
        else acc = acc + ci_dataa * 32'd3 + ci_datab;
        if (resp_on) cnt = $urandom_range(lat_max, lat_min);
      end else if (cnt > 0) begin
        check("operand_hold", {ci_n, ci_dataa, ci_datab}, held);
        cnt--;
        if (cnt == 0) begin
          ci_done = 1'b1;
          ci_result = held.n ? pend : $urandom;
        end
      end else if (spurious && $urandom_range(7, 0) == 0) begin
        ci_done = 1'b1;
        ci_result = $urandom;
      end
    end
  end

  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      res_ready = ($urandom_range(100, 1) <= ready_pct);
    end
  end

  // Result stream monitor: stability while stalled and in-order contents.
  initial begin
    logic pv, phs;
    logic [4:0] pt;
    logic [31:0] pd;
    res_t e;
    pv = 1'b0; phs = 1'b0; pt = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin pv = 1'b0; continue; end
      if (res_valid && pv && !phs) check("res_stable", {res_target, res_data}, {pt, pd});
      if (res_valid && res_ready) begin
        results_seen++;
        obs_tgt.push_back(res_target);
        check("res_expected", {95'd0, exp_res.size() != 0}, 96'd1);
        if (exp_res.size() != 0) begin
          e = exp_res.pop_front();
          check("result", {res_target, res_data}, e);
        end
      end
      pv = res_valid; phs = res_valid && res_ready; pt = res_target; pd = res_data;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic write_msg();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] f, input logic [4:0] l);
    plan_run(f, l);
    first_tgt = f; last_tgt = l; go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned c;
    c = 0;
    while (busy && c < 3000) begin step(); c++; end
    check({name, "_finished"}, {95'd0, busy}, 96'd0);
    check({name, "_insn_drained"}, 96'(exp_insn.size()), 96'd0);
    check({name, "_res_drained"}, 96'(exp_res.size()), 96'd0);
  endtask

  initial begin
    string s;
    logic [7:0] bytes [64];
    int unsigned c, s0, r0;
    logic [4:0] f;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
    first_tgt = '0; last_tgt = '0;
    repeat (3) step();
    check("rst_busy", {95'd0, busy}, 96'd0);
    check("rst_start", {95'd0, ci_start}, 96'd0);
    check("rst_n", {95'd0, ci_n}, 96'd0);
    check("rst_operands", {ci_dataa, ci_datab}, 96'd0);
    check("rst_res", {res_valid, res_target, res_data}, 96'd0);
    check("rst_err", {95'd0, err}, 96'd0);
    check("clk_en", {95'd0, ci_clk_en}, 96'd1);
    check("rst_ci_reset", {95'd0, ci_reset}, 96'd1);
    reset = 1'b0;
    step();
    check("ci_reset_low", {95'd0, ci_reset}, 96'd0);

    s = "XXXX Keep your FPGA spinning!";
    for (int i = 0; i < 64; i++) bytes[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) bytes[i] = s[i];
    bytes[s.len()] = 8'h80;
    bytes[63] = 8'(s.len() * 8);
    for (int i = 0; i < 16; i++) msg[i] = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
    check("msg_w7", 96'(msg[7]), 96'h21800000);
    check("msg_w15", 96'(msg[15]), 96'h000000E8);
    write_msg();

    // Single target 0, fixed latency 3.
    obs_insn.delete(); obs_tgt.delete(); s0 = starts_seen;
    start_run(5'd0, 5'd0);
    wait_idle("run_0_0");
    check("run_0_0_starts", 96'(starts_seen - s0), 96'd9);
    check("run_0_0_first_load", 96'(obs_insn.size() > 0 ? obs_insn[0] : '0),
          {31'd0, 1'b0, 32'h58585858, 32'h204B6565});
    check("run_0_0_query", 96'(obs_insn.size() > 8 ? obs_insn[8] : '0), {31'd0, 1'b1, 64'd0});
    check("run_0_0_tgt", 96'(obs_tgt.size() == 1 ? obs_tgt[0] : 5'd31), 96'd0);
    check("run_0_0_data", 96'(res_data), 96'(model_result(5'd0)));

    // Wrapping range 30..1.
    obs_tgt.delete(); s0 = starts_seen;
    start_run(5'd30, 5'd1);
    wait_idle("run_wrap");
    check("wrap_starts", 96'(starts_seen - s0), 96'd36);
    check("wrap_order", {76'd0, obs_tgt.size() == 4 ? {obs_tgt[0], obs_tgt[1], obs_tgt[2], obs_tgt[3]} : 20'd0},
          {76'd0, 5'd30, 5'd31, 5'd0, 5'd1});

    // Back-pressure in EMIT.
    ready_pct = 0;
    start_run(5'd5, 5'd6);
    c = 0;
    while (!res_valid && c < 500) begin step(); c++; end
    check("stall_reached", {95'd0, res_valid}, 96'd1);
    s0 = starts_seen;
    for (int i = 0; i < 20; i++) begin
      step();
      check("stall_valid", {95'd0, res_valid}, 96'd1);
    end
    check("stall_no_start", 96'(starts_seen), 96'(s0));
    ready_pct = 100;
    wait_idle("run_stall");

    // Host writes while busy must not reach the buffer.
    obs_insn.delete();
    start_run(5'd2, 5'd3);
    repeat (3) step();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEADBEEF;
    repeat (3) step();
    wr_en = 1'b0;
    wait_idle("run_wr_busy");
    check("wr_busy_word0", 96'(obs_insn.size() > 9 ? obs_insn[9].a : '0), 96'h58585858);

    // Reset while waiting on the target query.
    lat_min = 12; lat_max = 12; obs_insn.delete(); r0 = results_seen;
    start_run(5'd7, 5'd7);
    c = 0;
    while (obs_insn.size() < 9 && c < 500) begin step(); c++; end
    step(); step();
    check("rst_mid_in_wait", {95'd0, busy}, 96'd1);
    reset = 1'b1;
    step();
    check("rst_mid_busy", {95'd0, busy}, 96'd0);
    check("rst_mid_valid", {95'd0, res_valid}, 96'd0);
    check("rst_mid_ci_reset", {95'd0, ci_reset}, 96'd1);
    reset = 1'b0;
    exp_insn.delete(); exp_res.delete();
    step();
    check("rst_mid_no_result", 96'(results_seen), 96'(r0));
    lat_min = 3; lat_max = 3;
    write_msg();
    start_run(5'd9, 5'd10);
    wait_idle("run_after_reset");

    // Randomized messages, ranges, latencies, back-pressure and stray done pulses.
    lat_min = 1; lat_max = 5; ready_pct = 60; spurious = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      write_msg();
      f = 5'($urandom_range(31, 0));
      start_run(f, 5'(f + 5'($urandom_range(2, 0))));
      wait_idle("run_rand");
    end
    spurious = 1'b0; ready_pct = 100; lat_min = 3; lat_max = 3;

`ifdef CI_TIMEOUT_EN
    resp_on = 1'b0;
    exp_insn.push_back({1'b0, msg[0], msg[1]});
    first_tgt = 5'd0; last_tgt = 5'd0; go = 1'b1;
    step();
    go = 1'b0;
    c = 0;
    while (!err && c < 100) begin step(); c++; end
    check("to_cycles", 96'(c), 96'd17);
    check("to_err", {95'd0, err}, 96'd1);
    check("to_ci_reset", {95'd0, ci_reset}, 96'd1);
    check("to_idle", {95'd0, busy}, 96'd0);
    step();
    check("to_ci_reset_pulse", {95'd0, ci_reset}, 96'd0);
    check("to_err_sticky", {95'd0, err}, 96'd1);
    resp_on = 1'b1;
    start_run(5'd4, 5'd4);
    check("to_err_cleared", {95'd0, err}, 96'd0);
    wait_idle("run_after_timeout");
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
